// File: rtl/testport_write_driver.sv
// Bus-master side of the testbench word-write port: takes write requests over
// valid/ready, drives one wen pulse per write, honours stall, inserts a low gap.
module testport_write_driver #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned STALL_MAX  = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [29:0]      req_addr,
  input  logic [31:0]      req_data,
  input  logic             stall,
  output logic [29:0]      addr,
  output logic [31:0]      data,
  output logic             wen,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic             err
);

  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } state_t;

  state_t             state, state_d;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [29:0]        addr_d;
  logic [31:0]        data_d;
  logic               wen_d, busy_d, ready_d, err_d;
  logic [CNT_W-1:0]   wr_count_d;

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_d     = state;
    stall_cnt_d = stall_cnt;
    gap_cnt_d   = gap_cnt;
    addr_d      = addr;
    data_d      = data;
    wen_d       = wen;
    busy_d      = busy;
    ready_d     = req_ready;
    err_d       = err;
    wr_count_d  = wr_count;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d     = WRITE;
          stall_cnt_d = '0;
          addr_d      = req_addr;
          data_d      = req_data;
          wen_d       = 1'b1;
          busy_d      = 1'b1;
          ready_d     = 1'b0;
        end
      end
      WRITE: begin
        // Leave WRITE on a taken write or on the last tolerated stall edge.
        if (!stall || (stall_cnt == STALL_W'(STALL_MAX - 1))) begin
          if (!stall) begin
            if (wr_count != '1) begin
              wr_count_d = wr_count + CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
          state_d   = GAP;
          gap_cnt_d = '0;
          addr_d    = '0;
          data_d    = '0;
          wen_d     = 1'b0;
        end else begin
          stall_cnt_d = stall_cnt + STALL_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        data_d  = '0;
        wen_d   = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stall_cnt <= '0;
      gap_cnt   <= '0;
      addr      <= '0;
      data      <= '0;
      wen       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      err       <= 1'b0;
      wr_count  <= '0;
    end else begin
      state     <= state_d;
      stall_cnt <= stall_cnt_d;
      gap_cnt   <= gap_cnt_d;
      addr      <= addr_d;
      data      <= data_d;
      wen       <= wen_d;
      busy      <= busy_d;
      req_ready <= ready_d;
      err       <= err_d;
      wr_count  <= wr_count_d;
    end
  end

endmodule
